// File: rtl/fifo_tap_mac.sv
// Snapshots the fifo tap line on a sample strobe and runs a sequential signed
// MAC against a coefficient set, one tap per clock, emitting one saturated sample.

module fifo_tap_mac_lane #(
   parameter int DATA_WIDTH = 18
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic signed [DATA_WIDTH-1:0] tap_d,
   input  logic signed [DATA_WIDTH-1:0] coef_d,
   output logic signed [DATA_WIDTH-1:0] tap_q,
   output logic signed [DATA_WIDTH-1:0] coef_q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_q  <= '0;
         coef_q <= '0;
      end else if (load) begin
         tap_q  <= tap_d;
         coef_q <= coef_d;
      end
   end
endmodule

module fifo_tap_mac #(
   parameter int FIFO_SIZE  = 4,
   parameter int DATA_WIDTH = 18
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] taps  [0:FIFO_SIZE-1],
   input  logic signed [DATA_WIDTH-1:0] coefs [0:FIFO_SIZE-1],
   output logic signed [DATA_WIDTH-1:0] y,
   output logic                         y_valid,
   output logic                         busy,
   output logic                         overrun
);
   localparam int IW = $clog2(FIFO_SIZE);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + $clog2(FIFO_SIZE);
   localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;
   localparam logic [IW-1:0]        LAST  = IW'(FIFO_SIZE - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                       state, next_state;
   logic        [IW-1:0]         idx;
   logic signed [AW-1:0]         acc;
   logic signed [AW-1:0]         acc_sh;
   logic signed [PW-1:0]         prod;
   logic signed [DATA_WIDTH-1:0] y_sat;
   logic signed [DATA_WIDTH-1:0] snap_tap  [0:FIFO_SIZE-1];
   logic signed [DATA_WIDTH-1:0] snap_coef [0:FIFO_SIZE-1];
   logic                         load;

   assign load = (state == IDLE) && sample_valid;

   // Snapshot isolates the running MAC from fifo shifts and coefficient updates.
   for (genvar g = 0; g < FIFO_SIZE; g++) begin : g_lane
      fifo_tap_mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .load   (load),
         .tap_d  (taps[g]),
         .coef_d (coefs[g]),
         .tap_q  (snap_tap[g]),
         .coef_q (snap_coef[g])
      );
   end

   always_comb begin
      prod   = snap_tap[idx] * snap_coef[idx];
      acc_sh = acc >>> (DATA_WIDTH - 1);
      if (acc_sh > Y_MAX)      y_sat = Y_MAX[DATA_WIDTH-1:0];
      else if (acc_sh < Y_MIN) y_sat = Y_MIN[DATA_WIDTH-1:0];
      else                     y_sat = acc_sh[DATA_WIDTH-1:0];
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sample_valid) next_state = MAC;
         MAC:     if (idx == LAST)  next_state = OUT;
         OUT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         acc     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         overrun <= 1'b0;
         case (state)
            IDLE: if (sample_valid) begin
               acc  <= '0;
               idx  <= '0;
               busy <= 1'b1;
            end
            MAC: begin
               acc     <= acc + AW'(prod);
               idx     <= idx + IW'(1);
               overrun <= sample_valid;
            end
            OUT: begin
               y       <= y_sat;
               y_valid <= 1'b1;
               busy    <= 1'b0;
               overrun <= sample_valid;
            end
            default: ;
         endcase
      end
   end
endmodule
